regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised CPU general-purpose register file with two synchronous read ports, one write port, write-to-read bypass, and a per-register busy scoreboard for in-flight writes. It is the successor to the current combinational register file, sitting between decode (rs1/rs2/rd) and writeback. It adds:
- registered outputs;
- deterministic read-during-write behaviour;
- a hardwired zero register;
- scoreboard bits so the hazard unit can stall on pending producers.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width
NUM_REGS, 32, number of implemented registers (must be ≤ 2**ADDR_W)
ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy
BYPASS, 1, when 1, same-cycle write data forwards to the read outputs; when 0, reads return the old value

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
enable  in  1  global enable; when low, no state changes and outputs hold
rs1  in  ADDR_W  read port 1 index
rs2  in  ADDR_W  read port 2 index
rd  in  ADDR_W  write index
din  in  DATA_W  write data
rw  in  1  write strobe
mark  in  1  issue strobe; sets the busy bit of mark_rd
mark_rd  in  ADDR_W  index of register gaining a pending producer
out1  out  DATA_W  registered read data, port 1
out2  out  DATA_W  registered read data, port 2
busy1  out  1  registered busy bit for rs1
busy2  out  1  registered busy bit for rs2
any_busy  out  1  OR of all busy bits (registered)

Behaviour:
- Reset (async, active-high) takes effect immediately, independent of clk and enable. It forces all NUM_REGS registers to 0, all busy bits to 0, and out1, out2, busy1, busy2 and any_busy to 0. Deasserting reset mid-operation resumes on the next rising edge from the all-zero state.
- All other updates occur on the rising edge of clk and only when enable=1. With enable=0, the array, busy bits and all outputs hold.
- Write: rw=1 writes din to reg[rd] at the edge and clears busy[rd].
  - Ignored when rd ≥ NUM_REGS.
  - Ignored when ZERO_REG=1 and rd=0.
- Mark: mark=1 sets busy[mark_rd].
  - Ignored when mark_rd ≥ NUM_REGS.
  - Ignored when ZERO_REG=1 and mark_rd=0.
- Mark and write to the same index in the same cycle: busy ends set (the new producer wins); the data write still happens.
- Read latency is 1 cycle. outN/busyN at edge k+1 reflect rsN sampled at edge k.
- Read-during-write with BYPASS=1, rw=1 and rd==rsN (valid, non-zero-reg): outN = din, and busyN reflects the post-edge busy value (0 unless mark hits the same index).
- Read-during-write with BYPASS=0: outN = old reg[rsN], and busyN = old busy[rsN].
- Read index ≥ NUM_REGS: outN = 0 and busyN = 0.
- Read of reg 0 with ZERO_REG=1: outN = 0 and busyN = 0, regardless of bypass.
- Both read ports are independent and may address the same register.
- any_busy equals the OR of the busy vector after the edge's updates, registered.
- No combinational path from any input to any output.

Test Plan:
- Reset clears everything: write reg[5]=0xDEADBEEF, then pulse reset between clock edges → out1, out2, busy1, busy2 and any_busy are 0 immediately; rs1=5 the next cycle reads 0.
- Basic write then read: write rd=3, din=0x12345678, and on the following cycle set rs1=3, rs2=3 → one edge later out1 = out2 = 0x12345678.
- Bypass (BYPASS=1): reg[7]=0x1, then in the same cycle rw=1, rd=7, din=0xAA and rs1=7 → out1 = 0xAA after one edge. Repeat with BYPASS=0 → out1 = 0x1.
- Zero register: rw=1, rd=0, din=0xFFFFFFFF, mark=1, mark_rd=0, rs1=0 → out1 = 0, busy1 = 0, any_busy = 0.
- Scoreboard sequence:
  - mark rd=9 → busy for rs1=9 reads 1 and any_busy = 1.
  - Then in one cycle, write rd=9 din=0x55 and mark rd=9 → busy1 stays 1.
  - Then write rd=9 alone → busy1 = 0 and any_busy = 0.
- Enable and range: with enable=0, issue rw=1, rd=4 and mark → no change, and outputs hold the previous values. With NUM_REGS=16, write rd=20 → ignored, and rs1=20 reads 0 with busy1=0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two registered read ports, one write port,
// write-to-read bypass and a per-register busy scoreboard.
// Latency: 1 cycle from rs1/rs2 to out/busy. No backpressure; enable=0 freezes all state.
// Ports: clk/reset (async, active-high), enable; rs1/rs2 read indices; rd/din/rw write port;
//        mark/mark_rd set a busy bit; out1/out2 data; busy1/busy2 per-port busy; any_busy.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] din,
  input  logic              rw,
  input  logic              mark,
  input  logic [ADDR_W-1:0] mark_rd,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic              busy1,
  output logic              busy2,
  output logic              any_busy
);

  // Storage spans the full index space so any index can address it directly;
  // entries at or above NUM_REGS are never written and stay constant zero.
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] out1_q, out1_d, out2_q, out2_d;
  logic              busy1_q, busy1_d, busy2_q, busy2_d;
  logic              any_busy_q, any_busy_d;
  logic              wr_ok, mk_ok;

  // An index is usable when implemented and not the hardwired zero register.
  function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
    return (32'(idx) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  always_comb begin
    wr_ok  = rw && idx_ok(rd);
    mk_ok  = mark && idx_ok(mark_rd);
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[rd] = din;
      busy_d[rd] = 1'b0;
    end
    // Applied after the write so a new producer wins over a retiring one.
    if (mk_ok) busy_d[mark_rd] = 1'b1;

    // With bypass the read sees the post-edge state (forwarded din / busy);
    // without it the read sees the state before this edge.
    out1_d  = '0;
    busy1_d = 1'b0;
    if (idx_ok(rs1)) begin
      out1_d  = (BYPASS != 0) ? regs_d[rs1] : regs_q[rs1];
      busy1_d = (BYPASS != 0) ? busy_d[rs1] : busy_q[rs1];
    end
    out2_d  = '0;
    busy2_d = 1'b0;
    if (idx_ok(rs2)) begin
      out2_d  = (BYPASS != 0) ? regs_d[rs2] : regs_q[rs2];
      busy2_d = (BYPASS != 0) ? busy_d[rs2] : busy_q[rs2];
    end
    any_busy_d = |busy_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q     <= '{default: '0};
      busy_q     <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
      busy1_q    <= 1'b0;
      busy2_q    <= 1'b0;
      any_busy_q <= 1'b0;
    end else if (enable) begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      busy1_q    <= busy1_d;
      busy2_q    <= busy2_d;
      any_busy_q <= any_busy_d;
    end
  end

  assign out1     = out1_q;
  assign out2     = out2_q;
  assign busy1    = busy1_q;
  assign busy2    = busy2_q;
  assign any_busy = any_busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances share one stimulus stream.
// Instance 0: BYPASS=1, NUM_REGS=32. Instance 1: BYPASS=0, NUM_REGS=16.
// Each instance has its own reference model of registers and busy flags.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        rw = 1'b0;
  logic        mark = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, mark_rd = '0;
  logic [31:0] din = '0;

  logic [31:0] out1_w [2];
  logic [31:0] out2_w [2];
  logic        busy1_w [2];
  logic        busy2_w [2];
  logic        any_w [2];

  int n_asserts = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .rs1(rs1), .rs2(rs2), .rd(rd), .din(din),
    .rw(rw), .mark(mark), .mark_rd(mark_rd), .out1(out1_w[0]), .out2(out2_w[0]),
    .busy1(busy1_w[0]), .busy2(busy2_w[0]), .any_busy(any_w[0]));

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(16), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .rs1(rs1), .rs2(rs2), .rd(rd), .din(din),
    .rw(rw), .mark(mark), .mark_rd(mark_rd), .out1(out1_w[1]), .out2(out2_w[1]),
    .busy1(busy1_w[1]), .busy2(busy2_w[1]), .any_busy(any_w[1]));

  // Reference model state
  logic [31:0] m_reg [2][32];
  bit          m_busy [2][32];
  logic [31:0] e_out1 [2];
  logic [31:0] e_out2 [2];
  bit          e_b1 [2];
  bit          e_b2 [2];
  bit          e_any [2];

  function automatic bit byp(int i);
    return (i == 0);
  endfunction

  function automatic int nr(int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic bit ok(int i, int idx);
    return (idx < nr(i)) && (idx != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[i][r]  = '0;
        m_busy[i][r] = 1'b0;
      end
      e_out1[i] = '0; e_out2[i] = '0;
      e_b1[i] = 1'b0; e_b2[i] = 1'b0; e_any[i] = 1'b0;
    end
  endtask

  task automatic model_edge(int i);
    logic [31:0] nreg [32];
    bit          nb [32];
    bit          any;
    if (!enable) return;
    for (int r = 0; r < 32; r++) begin
      nreg[r] = m_reg[i][r];
      nb[r]   = m_busy[i][r];
    end
    if (rw && ok(i, int'(rd))) begin
      nreg[rd] = din;
      nb[rd]   = 1'b0;
    end
    if (mark && ok(i, int'(mark_rd))) nb[mark_rd] = 1'b1;
    e_out1[i] = !ok(i, int'(rs1)) ? 32'h0 : (byp(i) ? nreg[rs1] : m_reg[i][rs1]);
    e_out2[i] = !ok(i, int'(rs2)) ? 32'h0 : (byp(i) ? nreg[rs2] : m_reg[i][rs2]);
    e_b1[i]   = !ok(i, int'(rs1)) ? 1'b0 : (byp(i) ? nb[rs1] : m_busy[i][rs1]);
    e_b2[i]   = !ok(i, int'(rs2)) ? 1'b0 : (byp(i) ? nb[rs2] : m_busy[i][rs2]);
    any = 1'b0;
    for (int r = 0; r < 32; r++) begin
      any = any | nb[r];
      m_reg[i][r]  = nreg[r];
      m_busy[i][r] = nb[r];
    end
    e_any[i] = any;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ctx);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s out1[%0d]", ctx, i), out1_w[i], e_out1[i]);
      chk($sformatf("%s out2[%0d]", ctx, i), out2_w[i], e_out2[i]);
      chk($sformatf("%s busy1[%0d]", ctx, i), 32'(busy1_w[i]), 32'(e_b1[i]));
      chk($sformatf("%s busy2[%0d]", ctx, i), 32'(busy2_w[i]), 32'(e_b2[i]));
      chk($sformatf("%s any_busy[%0d]", ctx, i), 32'(any_w[i]), 32'(e_any[i]));
    end
  endtask

  // One clock edge: model follows the inputs sampled at the edge, then compare.
  task automatic cycle(string ctx);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all(ctx);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset_state");
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;

    // Reset clears everything
    rw = 1; rd = 5; din = 32'hDEADBEEF; rs1 = 5;
    cycle("wr5");
    rw = 0;
    cycle("rd5");
    chk("pre_reset_out1_b", out1_w[1], 32'hDEADBEEF);
    reset_pulse();
    chk("reset_out1_a", out1_w[0], 32'h0);
    rs1 = 5;
    cycle("after_reset_rd5");
    chk("after_reset_rd5_a", out1_w[0], 32'h0);

    // Basic write then read on both ports
    rw = 1; rd = 3; din = 32'h12345678;
    cycle("wr3");
    rw = 0; rs1 = 3; rs2 = 3;
    cycle("rd3");
    chk("basic_out1_a", out1_w[0], 32'h12345678);
    chk("basic_out2_b", out2_w[1], 32'h12345678);

    // Read-during-write: bypass on instance 0, old value on instance 1
    rw = 1; rd = 7; din = 32'h1; rs1 = 0;
    cycle("wr7_init");
    rw = 1; rd = 7; din = 32'hAA; rs1 = 7;
    cycle("rdw7");
    chk("bypass_on", out1_w[0], 32'hAA);
    chk("bypass_off", out1_w[1], 32'h1);

    // Zero register
    rw = 1; rd = 0; din = 32'hFFFFFFFF; mark = 1; mark_rd = 0; rs1 = 0;
    cycle("zero_reg");
    chk("zero_out1_a", out1_w[0], 32'h0);
    chk("zero_any_a", 32'(any_w[0]), 32'h0);

    // Scoreboard sequence on register 9
    rw = 0; mark = 1; mark_rd = 9; rs1 = 9;
    cycle("mark9");
    mark = 0;
    cycle("mark9_hold");
    chk("sb_busy1_b", 32'(busy1_w[1]), 32'h1);
    chk("sb_any_a", 32'(any_w[0]), 32'h1);
    rw = 1; rd = 9; din = 32'h55; mark = 1; mark_rd = 9;
    cycle("wr_mark9");
    chk("sb_mark_wins_a", 32'(busy1_w[0]), 32'h1);
    mark = 0;
    cycle("wr9");
    chk("sb_clear_a", 32'(busy1_w[0]), 32'h0);
    chk("sb_clear_any_b", 32'(any_w[1]), 32'h0);
    rw = 0;
    cycle("rd9");
    chk("sb_clear_b", 32'(busy1_w[1]), 32'h0);

    // Enable low freezes everything
    rs1 = 3;
    cycle("pre_disable");
    enable = 0; rw = 1; rd = 4; din = 32'h44444444; mark = 1; mark_rd = 4; rs1 = 9;
    cycle("disabled");
    chk("disabled_hold_a", out1_w[0], 32'h12345678);
    enable = 1; rw = 0; mark = 0; rs1 = 4;
    cycle("after_disable");
    chk("disabled_nowrite_a", out1_w[0], 32'h0);

    // Out-of-range index on the 16-entry instance
    rw = 1; rd = 20; din = 32'hCAFEF00D; mark = 1; mark_rd = 20;
    cycle("wr20");
    rw = 0; mark = 0; rs1 = 20;
    cycle("rd20");
    chk("range_out1_b", out1_w[1], 32'h0);
    chk("range_busy1_b", 32'(busy1_w[1]), 32'h0);
    chk("range_out1_a", out1_w[0], 32'hCAFEF00D);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) reset_pulse();
      enable  = ($urandom_range(0, 9) != 0);
      rw      = $urandom_range(0, 1);
      mark    = ($urandom_range(0, 2) == 0);
      rd      = 5'($urandom_range(0, 31));
      mark_rd = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs1     = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2     = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
      din     = $urandom;
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
